draw_scheduler: RTL and testbench

- Per-frame sequencer for the shared rectangle drawing datapath (object-select mux feeding the rectangle drawer).
- Each frame runs two phases. The erase phase redraws every object drawn last frame in background colour. The draw phase then draws every currently alive object in its own colour.
- For each object it drives the object-select index, starts the drawer, and waits for its done handshake.
- It brackets the phases with a one-cycle latch pulse so the select mux captures fresh positions between erase and draw.

---
 rtl/draw_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_draw_scheduler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_scheduler.sv
// Per-frame sequencer for the shared rectangle drawer: erases last frame's objects,
// pulses the select-mux latch, then draws every alive object in index order.
module draw_scheduler #(
    parameter int NUM_OBJ = 5,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic [NUM_OBJ-1:0] obj_mask,
    input  logic               draw_done,
    output logic [3:0]         control_signal,
    output logic               draw_start,
    output logic               erase,
    output logic               latch_pulse,
    output logic               frame_done,
    output logic               busy,
    output logic               overrun,
    output logic [7:0]         timeout_cnt
);

    localparam int TW = $clog2(TIMEOUT);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SCAN  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_LATCH = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic PH_ERASE = 1'b0;
    localparam logic PH_DRAW  = 1'b1;

    localparam logic [3:0]    LAST_IDX = 4'(NUM_OBJ);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [2:0]         r_state;
    logic [3:0]         r_idx;
    logic               r_phase;
    logic [NUM_OBJ-1:0] r_prev_mask;
    logic [NUM_OBJ-1:0] r_draw_mask;
    logic               r_pending;
    logic [TW-1:0]      r_timer;
    logic               r_overrun;
    logic [7:0]         r_timeout_cnt;

    logic [3:0]         r_control;
    logic               r_draw_start;
    logic               r_erase;
    logic               r_latch;
    logic               r_frame_done;
    logic               r_busy;

    logic [2:0]         w_state_nx;
    logic [3:0]         w_idx_nx;
    logic               w_phase_nx;
    logic [NUM_OBJ-1:0] w_prev_mask_nx;
    logic [NUM_OBJ-1:0] w_draw_mask_nx;
    logic               w_pending_nx;
    logic [TW-1:0]      w_timer_nx;
    logic               w_overrun_nx;
    logic [7:0]         w_tcnt_nx;
    logic [15:0]        w_active_ext;
    logic               w_obj_en;
    logic               w_in_obj;

    // Erase walks last frame's mask, draw walks the mask captured at the latch
    always_comb begin
        if (r_phase == PH_ERASE) begin
            w_active_ext = 16'(r_prev_mask);
        end else begin
            w_active_ext = 16'(r_draw_mask);
        end
    end

    assign w_obj_en = w_active_ext[r_idx];
    assign w_in_obj = (w_state_nx == ST_START) || (w_state_nx == ST_WAIT);

    // Next-state, frame bookkeeping and tick queuing
    always_comb begin
        w_state_nx     = r_state;
        w_idx_nx       = r_idx;
        w_phase_nx     = r_phase;
        w_prev_mask_nx = r_prev_mask;
        w_draw_mask_nx = r_draw_mask;
        w_pending_nx   = r_pending;
        w_timer_nx     = r_timer;
        w_overrun_nx   = r_overrun;
        w_tcnt_nx      = r_timeout_cnt;

        // Only one tick can be queued behind a running frame; a second is lost
        if (frame_tick && (r_state != ST_IDLE)) begin
            if (r_pending) begin
                w_overrun_nx = 1'b1;
            end else begin
                w_pending_nx = 1'b1;
            end
        end else begin
            w_overrun_nx = r_overrun;
        end

        case (r_state)
            ST_IDLE: begin
                if (frame_tick || r_pending) begin
                    w_state_nx   = ST_SCAN;
                    w_phase_nx   = PH_ERASE;
                    w_idx_nx     = 4'd0;
                    w_pending_nx = 1'b0;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (r_idx == LAST_IDX) begin
                    if (r_phase == PH_ERASE) begin
                        w_state_nx = ST_LATCH;
                    end else begin
                        w_state_nx = ST_DONE;
                    end
                end else if (w_obj_en) begin
                    w_state_nx = ST_START;
                end else begin
                    w_idx_nx = r_idx + 4'd1;
                end
            end
            ST_START: begin
                w_timer_nx = {TW{1'b0}};
                w_state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving on the last timer cycle still counts as success
                if (draw_done) begin
                    w_idx_nx   = r_idx + 4'd1;
                    w_state_nx = ST_SCAN;
                end else if (r_timer == TMO_LAST) begin
                    if (r_timeout_cnt != 8'hFF) begin
                        w_tcnt_nx = r_timeout_cnt + 8'd1;
                    end else begin
                        w_tcnt_nx = r_timeout_cnt;
                    end
                    w_idx_nx   = r_idx + 4'd1;
                    w_state_nx = ST_SCAN;
                end else begin
                    w_timer_nx = r_timer + TW'(1);
                end
            end
            ST_LATCH: begin
                w_draw_mask_nx = obj_mask;
                w_phase_nx     = PH_DRAW;
                w_idx_nx       = 4'd0;
                w_state_nx     = ST_SCAN;
            end
            ST_DONE: begin
                w_prev_mask_nx = r_draw_mask;
                if (r_pending) begin
                    w_pending_nx = 1'b0;
                    w_phase_nx   = PH_ERASE;
                    w_idx_nx     = 4'd0;
                    w_state_nx   = ST_SCAN;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_idx_nx   = 4'd0;
            end
        endcase
    end

    // Sequencer state and sticky status
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_idx         <= 4'd0;
            r_phase       <= PH_ERASE;
            r_prev_mask   <= {NUM_OBJ{1'b0}};
            r_draw_mask   <= {NUM_OBJ{1'b0}};
            r_pending     <= 1'b0;
            r_timer       <= {TW{1'b0}};
            r_overrun     <= 1'b0;
            r_timeout_cnt <= 8'd0;
        end else begin
            r_state       <= w_state_nx;
            r_idx         <= w_idx_nx;
            r_phase       <= w_phase_nx;
            r_prev_mask   <= w_prev_mask_nx;
            r_draw_mask   <= w_draw_mask_nx;
            r_pending     <= w_pending_nx;
            r_timer       <= w_timer_nx;
            r_overrun     <= w_overrun_nx;
            r_timeout_cnt <= w_tcnt_nx;
        end
    end

    // Moore outputs registered from the state being entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_control    <= 4'd0;
            r_draw_start <= 1'b0;
            r_erase      <= 1'b0;
            r_latch      <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_control    <= w_in_obj ? w_idx_nx : 4'd0;
            r_draw_start <= (w_state_nx == ST_START);
            r_erase      <= w_in_obj && (w_phase_nx == PH_ERASE);
            r_latch      <= (w_state_nx == ST_LATCH);
            r_frame_done <= (w_state_nx == ST_DONE);
            r_busy       <= (w_state_nx != ST_IDLE);
        end
    end

    assign control_signal = r_control;
    assign draw_start     = r_draw_start;
    assign erase          = r_erase;
    assign latch_pulse    = r_latch;
    assign frame_done     = r_frame_done;
    assign busy           = r_busy;
    assign overrun        = r_overrun;
    assign timeout_cnt    = r_timeout_cnt;

endmodule

// File: tb/tb_draw_scheduler.sv
// Self-checking bench for draw_scheduler: hand-computed frame table, corner sequences,
// and a procedural per-frame reference model compared every cycle under random stimulus.
module tb_draw_scheduler;

    localparam int NUM_OBJ = 5;
    localparam int TIMEOUT = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               frame_tick = 1'b0;
    logic [NUM_OBJ-1:0] obj_mask = '0;
    logic               drv_done = 1'b0;
    logic               inj_done = 1'b0;
    logic               draw_done;
    logic [3:0]         control_signal;
    logic               draw_start, erase, latch_pulse, frame_done, busy, overrun;
    logic [7:0]         timeout_cnt;

    assign draw_done = drv_done | inj_done;

    draw_scheduler #(.NUM_OBJ(NUM_OBJ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .obj_mask(obj_mask),
        .draw_done(draw_done), .control_signal(control_signal), .draw_start(draw_start),
        .erase(erase), .latch_pulse(latch_pulse), .frame_done(frame_done), .busy(busy),
        .overrun(overrun), .timeout_cnt(timeout_cnt)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int dly = 3;
    bit rnd_mode = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drawer: done pulse dly cycles after a start (dly=0: never)
    int dcnt = 0;
    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            dcnt = 0; drv_done = 1'b0;
        end else if (draw_start) begin
            dcnt = rnd_mode ? int'($urandom_range(TIMEOUT, 0)) : dly;
            drv_done = 1'b0;
        end else if (dcnt > 0) begin
            dcnt--; drv_done = (dcnt == 0);
        end else begin
            drv_done = 1'b0;
        end
    end

    // ---------------- reference model ----------------
    int e_busy, e_cs, e_st, e_er, e_la, e_fd, e_ovr, e_tcnt;
    bit m_abort, m_pend, m_ovr;
    int m_tcnt;
    logic [NUM_OBJ-1:0] m_prev, m_draw, s_mask;
    bit s_tick, s_done;

    task automatic cyc(input int b, input int cs, input int st, input int er, input int la, input int fd);
        if (m_abort) return;
        e_busy = b; e_cs = cs; e_st = st; e_er = er; e_la = la; e_fd = fd;
        e_ovr = int'(m_ovr); e_tcnt = m_tcnt;
        @(posedge clk or negedge reset);
        if (!reset) begin m_abort = 1'b1; return; end
        s_tick = frame_tick; s_done = draw_done; s_mask = obj_mask;
        if (b != 0 && s_tick) begin
            if (m_pend) m_ovr = 1'b1; else m_pend = 1'b1;
        end
    endtask

    task automatic model_phase(input int er, input logic [NUM_OBJ-1:0] mask);
        for (int i = 0; i < NUM_OBJ; i++) begin
            cyc(1, 0, 0, 0, 0, 0); if (m_abort) return;
            if (mask[i]) begin
                cyc(1, i, 1, er, 0, 0); if (m_abort) return;
                for (int n = 0; n < TIMEOUT; n++) begin
                    cyc(1, i, 0, er, 0, 0); if (m_abort) return;
                    if (s_done) break;
                    if (n == TIMEOUT - 1) begin
                        if (m_tcnt < 255) m_tcnt++;
                    end
                end
            end
        end
        cyc(1, 0, 0, 0, 0, 0);
    endtask

    task automatic model_run();
        bit p;
        forever begin
            cyc(0, 0, 0, 0, 0, 0); if (m_abort) return;
            if (s_tick || m_pend) begin
                m_pend = 1'b0;
                p = 1'b1;
                while (p) begin
                    model_phase(1, m_prev); if (m_abort) return;
                    cyc(1, 0, 0, 0, 1, 0); if (m_abort) return;
                    m_draw = s_mask;
                    model_phase(0, m_draw); if (m_abort) return;
                    p = m_pend;
                    cyc(1, 0, 0, 0, 0, 1); if (m_abort) return;
                    m_prev = m_draw;
                    if (p) m_pend = 1'b0;
                end
            end
        end
    endtask

    initial begin
        forever begin
            m_abort = 1'b0; m_pend = 1'b0; m_ovr = 1'b0; m_tcnt = 0;
            m_prev = '0; m_draw = '0;
            e_busy = 0; e_cs = 0; e_st = 0; e_er = 0; e_la = 0; e_fd = 0; e_ovr = 0; e_tcnt = 0;
            wait (reset === 1'b1);
            model_run();
        end
    end

    always @(negedge clk) begin
        if (chk_en && reset) begin
            chk("m_busy", int'(busy), e_busy);
            chk("m_ctrl", int'(control_signal), e_cs);
            chk("m_start", int'(draw_start), e_st);
            chk("m_erase", int'(erase), e_er);
            chk("m_latch", int'(latch_pulse), e_la);
            chk("m_fdone", int'(frame_done), e_fd);
            chk("m_ovr", int'(overrun), e_ovr);
            chk("m_tcnt", int'(timeout_cnt), e_tcnt);
        end
    end

    // ---------------- directed tests ----------------
    typedef struct {
        logic [NUM_OBJ-1:0] mask;
        int d; bit inj; int fd; int starts; int first; int fcs; int fer; int tcnt;
    } vec_t;
    vec_t tbl [7];

    task automatic run_frame(input bit inj, output int fd, output int n_st, output int first,
                             output int fcs, output int fer);
        fd = -1; n_st = 0; first = -1; fcs = -1; fer = -1;
        @(negedge clk); frame_tick = 1'b1;
        for (int k = 1; k < 300; k++) begin
            @(negedge clk); frame_tick = 1'b0; inj_done = 1'b0;
            if (draw_start) begin
                n_st++;
                if (first < 0) begin first = k; fcs = int'(control_signal); fer = int'(erase); end
                if (inj) inj_done = 1'b1;
            end
            if (frame_done) begin fd = k; break; end
        end
        inj_done = 1'b0;
    endtask

    task automatic chk_zero_outs(input string pfx);
        chk({pfx, "_busy"}, int'(busy), 0);
        chk({pfx, "_ctrl"}, int'(control_signal), 0);
        chk({pfx, "_start"}, int'(draw_start), 0);
        chk({pfx, "_erase"}, int'(erase), 0);
        chk({pfx, "_latch"}, int'(latch_pulse), 0);
        chk({pfx, "_fdone"}, int'(frame_done), 0);
        chk({pfx, "_ovr"}, int'(overrun), 0);
        chk({pfx, "_tcnt"}, int'(timeout_cnt), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int fd, ns, fi, fc, fe, nfd, fd1, fd2, bafter, got;
        // mask, delay, inj, fd, starts, first, fcs, ferase, tcnt (frames run back to back)
        tbl[0] = '{5'b00001, 3, 1'b0, 18, 1, 9, 0, 0, 0};
        tbl[1] = '{5'b10010, 3, 1'b0, 26, 3, 2, 0, 1, 0};
        tbl[2] = '{5'b00000, 3, 1'b0, 22, 2, 3, 1, 1, 0};
        tbl[3] = '{5'b11111, 1, 1'b0, 24, 5, 9, 0, 0, 0};
        tbl[4] = '{5'b00100, 0, 1'b0, 68, 6, 2, 0, 1, 6};
        tbl[5] = '{5'b01000, 8, 1'b0, 32, 2, 4, 2, 1, 6};
        tbl[6] = '{5'b00001, 3, 1'b1, 22, 2, 5, 3, 1, 6};

        repeat (2) @(negedge clk);
        chk_zero_outs("reset");
        reset = 1'b1; chk_en = 1'b1;
        repeat (2) @(negedge clk);

        inj_done = 1'b1; @(negedge clk); inj_done = 1'b0; @(negedge clk);
        chk("idle_done_busy", int'(busy), 0);
        chk("idle_done_start", int'(draw_start), 0);

        for (int r = 0; r < 7; r++) begin
            dly = tbl[r].d; obj_mask = tbl[r].mask;
            run_frame(tbl[r].inj, fd, ns, fi, fc, fe);
            chk($sformatf("row%0d_fdone_cycle", r), fd, tbl[r].fd);
            chk($sformatf("row%0d_starts", r), ns, tbl[r].starts);
            chk($sformatf("row%0d_first_start", r), fi, tbl[r].first);
            chk($sformatf("row%0d_first_ctrl", r), fc, tbl[r].fcs);
            chk($sformatf("row%0d_first_erase", r), fe, tbl[r].fer);
            chk($sformatf("row%0d_tcnt", r), int'(timeout_cnt), tbl[r].tcnt);
            repeat (2) @(negedge clk);
        end

        // two ticks during a busy frame: one queued frame, sticky overrun
        obj_mask = 5'b00000; dly = 3;
        nfd = 0; fd1 = -1; fd2 = -1; bafter = -1;
        @(negedge clk); frame_tick = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            frame_tick = (k == 3 || k == 5);
            if (fd1 > 0 && k == fd1 + 1) bafter = int'(busy);
            if (k == 10) chk("ovr_set", int'(overrun), 1);
            if (frame_done) begin nfd++; if (nfd == 1) fd1 = k; else fd2 = k; end
        end
        chk("ovr_frames", nfd, 2);
        chk("ovr_fd1", fd1, 18);
        chk("ovr_fd2", fd2, 32);
        chk("ovr_busy_after_done", bafter, 1);
        chk("ovr_idle_end", int'(busy), 0);
        chk("ovr_sticky", int'(overrun), 1);

        // reset in WAIT clears everything; next frame has nothing to erase
        obj_mask = 5'b11111; dly = 1;
        run_frame(1'b0, fd, ns, fi, fc, fe);
        chk("pre_rst_fd", fd, 24);
        chk("pre_rst_starts", ns, 5);
        repeat (2) @(negedge clk);
        dly = 0; got = -1;
        @(negedge clk); frame_tick = 1'b1;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk); frame_tick = 1'b0;
            if (draw_start) begin got = k; break; end
        end
        chk("rst_erase_start", got, 2);
        @(negedge clk);
        chk("rst_in_wait_busy", int'(busy), 1);
        #2 reset = 1'b0;
        #1 chk_zero_outs("rst_wait");
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        obj_mask = 5'b00000; dly = 3;
        run_frame(1'b0, fd, ns, fi, fc, fe);
        chk("post_rst_fd", fd, 14);
        chk("post_rst_starts", ns, 0);
        repeat (2) @(negedge clk);

        // timeout counter saturation
        obj_mask = 5'b11111; dly = 0;
        run_frame(1'b0, fd, ns, fi, fc, fe);
        chk("sat_first_fd", fd, 59);
        chk("sat_first_tcnt", int'(timeout_cnt), 5);
        for (int f = 0; f < 24; f++) begin
            repeat (1) @(negedge clk);
            run_frame(1'b0, fd, ns, fi, fc, fe);
        end
        chk("sat_fd", fd, 104);
        chk("sat_tcnt_245", int'(timeout_cnt), 245);
        for (int f = 0; f < 2; f++) begin
            repeat (1) @(negedge clk);
            run_frame(1'b0, fd, ns, fi, fc, fe);
        end
        chk("sat_tcnt_255", int'(timeout_cnt), 255);
        repeat (2) @(negedge clk);

        // random traffic against the reference model
        rnd_mode = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            frame_tick = ($urandom_range(39, 0) == 0);
            obj_mask   = NUM_OBJ'($urandom);
            inj_done   = ($urandom_range(49, 0) == 0);
        end
        frame_tick = 1'b0; inj_done = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
